// File: rtl/fpu_requester_if.sv
// Bundle of the upstream job port, fpu handshake and result port seen by fpu_requester.
// master is the requester's view; slave is the view of whatever surrounds it.
interface fpu_requester_if #(
  parameter int bitness = 32
);
  logic               job_valid;
  logic               job_ready;
  logic [bitness-1:0] job_a;
  logic [bitness-1:0] job_b;
  logic [3:0]         job_cmd;

  logic               fpu_input_rdy;
  logic               fpu_input_ack;
  logic [bitness-1:0] fpu_data_a;
  logic [bitness-1:0] fpu_data_b;
  logic [3:0]         fpu_command;
  logic               fpu_output_rdy;
  logic               fpu_output_ack;
  logic [bitness-1:0] fpu_result;

  logic               res_valid;
  logic               res_ready;
  logic [bitness-1:0] res_data;
  logic               res_error;
  logic               busy;

  modport master (
    input  job_valid, job_a, job_b, job_cmd,
    input  fpu_input_ack, fpu_output_rdy, fpu_result,
    input  res_ready,
    output job_ready,
    output fpu_input_rdy, fpu_data_a, fpu_data_b, fpu_command, fpu_output_ack,
    output res_valid, res_data, res_error, busy
  );

  modport slave (
    output job_valid, job_a, job_b, job_cmd,
    output fpu_input_ack, fpu_output_rdy, fpu_result,
    output res_ready,
    input  job_ready,
    input  fpu_input_rdy, fpu_data_a, fpu_data_b, fpu_command, fpu_output_ack,
    input  res_valid, res_data, res_error, busy
  );
endinterface

// File: rtl/fpu_requester.sv
// Drives one job at a time into a non-pipelined fpu, collects its result into a small FIFO,
// and substitutes an error entry when the fpu fails to answer within the watchdog window.
module fpu_requester #(
  parameter int bitness        = 32,
  parameter int RES_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic             clock,
  input logic             reset_n,
  fpu_requester_if.master bus
);

  localparam int PW = $clog2(RES_DEPTH);
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WDOG_LIMIT = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RES, ACK, RELEASE} state_t;

  state_t             state;
  logic [WW-1:0]      wdog;
  logic               fpu_rdy;
  logic               fpu_ack;
  logic [bitness-1:0] op_a;
  logic [bitness-1:0] op_b;
  logic [3:0]         op_cmd;

  logic [PW:0]        wr_ptr;
  logic [PW:0]        rd_ptr;
  logic [PW:0]        count;
  logic [bitness-1:0] mem_data [RES_DEPTH];
  logic               mem_err  [RES_DEPTH];

  logic               accept;
  logic               timeout;
  logic               push;
  logic               pop;
  logic [bitness-1:0] push_data;
  logic               push_err;
  logic               not_empty;

  assign count     = wr_ptr - rd_ptr;
  assign not_empty = (count != '0);

  // A job is only taken when a FIFO slot is guaranteed for its result, so push never overflows.
  assign bus.job_ready = reset_n && (state == IDLE) && (count < (PW + 1)'(RES_DEPTH));
  assign accept        = bus.job_valid && bus.job_ready;
  assign pop           = bus.res_ready && not_empty;

  // NOTE: every signal assigned here gets a default first so no latch can be inferred.
  always_comb begin
    timeout   = 1'b0;
    push      = 1'b0;
    push_data = bus.fpu_result;
    push_err  = 1'b0;
    if (wdog == WDOG_LIMIT) begin
      timeout = ((state == ISSUE) && !bus.fpu_input_ack) ||
                ((state == WAIT_RES) && !bus.fpu_output_rdy);
    end
    if ((state == WAIT_RES) && bus.fpu_output_rdy) begin
      push = 1'b1;
    end else if (timeout) begin
      push      = 1'b1;
      push_data = '0;
      push_err  = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      wdog    <= '0;
      fpu_rdy <= 1'b0;
      fpu_ack <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      op_cmd  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a    <= bus.job_a;
            op_b    <= bus.job_b;
            op_cmd  <= bus.job_cmd;
            fpu_rdy <= 1'b1;
            wdog    <= '0;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          // Saturate so an ack on the final cycle leaves WAIT_RES no fresh budget.
          if (wdog != WDOG_LIMIT) wdog <= wdog + WW'(1);
          if (bus.fpu_input_ack) begin
            fpu_rdy <= 1'b0;
            state   <= WAIT_RES;
          end else if (timeout) begin
            fpu_rdy <= 1'b0;
            state   <= IDLE;
          end
        end
        WAIT_RES: begin
          if (wdog != WDOG_LIMIT) wdog <= wdog + WW'(1);
          if (bus.fpu_output_rdy) begin
            fpu_ack <= 1'b1;
            state   <= ACK;
          end else if (timeout) begin
            state <= IDLE;
          end
        end
        ACK: begin
          fpu_ack <= 1'b0;
          state   <= RELEASE;
        end
        RELEASE: begin
          // Hold off until the fpu withdraws the result so it is not captured twice.
          if (!bus.fpu_output_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PW + 1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW + 1)'(1);
    end
  end

  // NOTE: FIFO storage is deliberately not reset; occupancy lives in the pointers and the head is masked when empty.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_data[wr_ptr[PW-1:0]] <= push_data;
      mem_err[wr_ptr[PW-1:0]]  <= push_err;
    end
  end

  assign bus.fpu_input_rdy  = fpu_rdy;
  assign bus.fpu_output_ack = fpu_ack;
  assign bus.fpu_data_a     = op_a;
  assign bus.fpu_data_b     = op_b;
  assign bus.fpu_command    = op_cmd;
  assign bus.res_valid      = not_empty;
  assign bus.res_data       = not_empty ? mem_data[rd_ptr[PW-1:0]] : '0;
  assign bus.res_error      = not_empty && mem_err[rd_ptr[PW-1:0]];
  assign bus.busy           = (state != IDLE);

endmodule

// File: tb/tb_fpu_requester.sv
// Directed bench for fpu_requester: a behavioural fpu with programmable ack/result/hold delays
// answers each issued job from a queue of hand-chosen results.
module tb_fpu_requester;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpu_requester_if #(.bitness(32)) bus ();

  fpu_requester #(
    .bitness        (32),
    .RES_DEPTH      (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural fpu responder.
  typedef enum {R_IDLE, R_ACKWAIT, R_ACKING, R_RESWAIT, R_OUT, R_HOLD} rs_t;
  rs_t         rs = R_IDLE;
  int          rcnt = 0;
  int          ack_delay = 1;
  int          res_delay = 5;
  int          hold = 0;
  bit          never_ack = 1'b0;
  logic [31:0] res_q [$];

  initial begin
    bus.fpu_input_ack  = 1'b0;
    bus.fpu_output_rdy = 1'b0;
    bus.fpu_result     = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.fpu_input_ack  = 1'b0;
        bus.fpu_output_rdy = 1'b0;
        rs = R_IDLE;
        res_q.delete();
        continue;
      end
      case (rs)
        R_IDLE: if (bus.fpu_input_rdy && !never_ack) begin
          rcnt = ack_delay;
          rs   = R_ACKWAIT;
        end
        R_ACKWAIT: if (rcnt <= 1) begin
          bus.fpu_input_ack = 1'b1;
          rs = R_ACKING;
        end else rcnt--;
        R_ACKING: if (!bus.fpu_input_rdy) begin
          bus.fpu_input_ack = 1'b0;
          rcnt = res_delay;
          rs   = R_RESWAIT;
        end
        R_RESWAIT: if (rcnt <= 1) begin
          bus.fpu_result     = (res_q.size() != 0) ? res_q.pop_front() : 32'hDEADBEEF;
          bus.fpu_output_rdy = 1'b1;
          rs = R_OUT;
        end else rcnt--;
        R_OUT: if (bus.fpu_output_ack) begin
          if (hold == 0) begin
            bus.fpu_output_rdy = 1'b0;
            rs = R_IDLE;
          end else begin
            rcnt = hold;
            rs   = R_HOLD;
          end
        end
        R_HOLD: begin
          rcnt--;
          if (rcnt <= 0) begin
            bus.fpu_output_rdy = 1'b0;
            rs = R_IDLE;
          end
        end
        default: rs = R_IDLE;
      endcase
    end
  end

  // Handshake monitor, sampled shortly after each rising edge.
  int   rdy_rises = 0;
  int   ack_rises = 0;
  int   ack_run = 0;
  int   ack_max = 0;
  int   early_idle = 0;
  logic prev_rdy = 1'b0;
  logic prev_ack = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        prev_rdy = 1'b0;
        prev_ack = 1'b0;
        ack_run  = 0;
        continue;
      end
      if (bus.fpu_input_rdy && !prev_rdy) rdy_rises++;
      if (bus.fpu_output_ack) begin
        if (!prev_ack) ack_rises++;
        ack_run++;
        if (ack_run > ack_max) ack_max = ack_run;
      end else ack_run = 0;
      if (bus.fpu_output_rdy && !bus.busy) early_idle++;
      prev_rdy = bus.fpu_input_rdy;
      prev_ack = bus.fpu_output_ack;
    end
  end

  task automatic send_job(input logic [31:0] a, input logic [31:0] b, input logic [3:0] cmd,
                          input string tag);
    bit ok = 1'b0;
    @(negedge clk);
    bus.job_a     = a;
    bus.job_b     = b;
    bus.job_cmd   = cmd;
    bus.job_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (bus.job_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_accept"}, ok, 1);
    if (ok) begin
      @(posedge clk);
      #1;
    end
    bus.job_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    check({tag, "_idle"}, bus.busy, 0);
  endtask

  task automatic wait_out_rdy(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (bus.fpu_output_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_out_rdy"}, ok, 1);
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp_data, input logic exp_err);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_valid"}, ok, 1);
    check({tag, "_data"}, bus.res_data, exp_data);
    check({tag, "_err"}, bus.res_error, exp_err);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_job_ready"}, bus.job_ready, 0);
    check({tag, "_in_rdy"}, bus.fpu_input_rdy, 0);
    check({tag, "_out_ack"}, bus.fpu_output_ack, 0);
    check({tag, "_res_valid"}, bus.res_valid, 0);
    check({tag, "_res_error"}, bus.res_error, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_data_a"}, bus.fpu_data_a, 0);
    check({tag, "_data_b"}, bus.fpu_data_b, 0);
    check({tag, "_cmd"}, bus.fpu_command, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    int n;
    bus.job_valid = 1'b0;
    bus.job_a     = '0;
    bus.job_b     = '0;
    bus.job_cmd   = '0;
    bus.res_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    rst_n = 1'b1;

    // 1: single job, ack after 1 cycle, result after 5
    res_q.push_back(32'h40400000);
    rdy_rises = 0; ack_rises = 0; ack_max = 0;
    send_job(32'h3F800000, 32'h40000000, 4'h0, "t1");
    check("t1_in_rdy", bus.fpu_input_rdy, 1);
    check("t1_data_a", bus.fpu_data_a, 32'h3F800000);
    check("t1_data_b", bus.fpu_data_b, 32'h40000000);
    wait_out_rdy("t1");
    check("t1_pre_valid", bus.res_valid, 0);
    @(posedge clk);
    #1;
    check("t1_post_valid", bus.res_valid, 1);
    check("t1_post_data", bus.res_data, 32'h40400000);
    wait_idle("t1");
    check("t1_rdy_pulses", rdy_rises, 1);
    check("t1_ack_pulses", ack_rises, 1);
    check("t1_ack_len", ack_max, 1);
    pop_check("t1_pop", 32'h40400000, 1'b0);
    @(negedge clk);
    check("t1_empty", bus.res_valid, 0);

    // 2: fill the FIFO with the consumer stalled, then drain in order
    res_q.push_back(32'h11111111);
    res_q.push_back(32'h22222222);
    res_q.push_back(32'h33333333);
    res_q.push_back(32'h44444444);
    send_job(32'h00000001, 32'h00000002, 4'h3, "t2_j0");
    send_job(32'h00000010, 32'h00000020, 4'h7, "t2_j1");
    send_job(32'h00000100, 32'h00000200, 4'h9, "t2_j2");
    send_job(32'hABCD0000, 32'h0000EF01, 4'hC, "t2_j3");
    wait_idle("t2");
    check("t2_cmd_hold", bus.fpu_command, 4'hC);
    check("t2_a_hold", bus.fpu_data_a, 32'hABCD0000);
    bus.job_valid = 1'b1;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.job_ready) n++;
    end
    bus.job_valid = 1'b0;
    check("t2_full_ready", n, 0);
    check("t2_full_busy", bus.busy, 0);
    pop_check("t2_pop0", 32'h11111111, 1'b0);
    @(negedge clk);
    check("t2_ready_after_pop", bus.job_ready, 1);
    pop_check("t2_pop1", 32'h22222222, 1'b0);
    pop_check("t2_pop2", 32'h33333333, 1'b0);
    pop_check("t2_pop3", 32'h44444444, 1'b0);
    @(negedge clk);
    check("t2_empty", bus.res_valid, 0);

    // 3: fpu never acks -> watchdog abort after 16 cycles
    never_ack = 1'b1;
    send_job(32'h5A5A5A5A, 32'hA5A5A5A5, 4'h2, "t3");
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.fpu_input_rdy) break;
      n++;
    end
    check("t3_rdy_cycles", n, 16);
    check("t3_busy", bus.busy, 0);
    pop_check("t3_timeout", 32'h0, 1'b1);
    never_ack = 1'b0;
    res_q.push_back(32'hCAFEF00D);
    send_job(32'h00000003, 32'h00000004, 4'h1, "t3_next");
    wait_idle("t3_next");
    pop_check("t3_next_pop", 32'hCAFEF00D, 1'b0);

    // 4: result held 3 cycles past ack -> single capture, IDLE only after release
    hold = 3;
    early_idle = 0;
    res_q.push_back(32'h12345678);
    send_job(32'h00000005, 32'h00000006, 4'h4, "t4");
    wait_idle("t4");
    check("t4_early_idle", early_idle, 0);
    pop_check("t4_pop", 32'h12345678, 1'b0);
    @(negedge clk);
    check("t4_single_push", bus.res_valid, 0);
    hold = 0;

    // 5: push and pop in the same cycle at count 1
    res_q.push_back(32'hAAAA0001);
    res_q.push_back(32'hBBBB0002);
    send_job(32'h00000007, 32'h00000008, 4'h5, "t5_a");
    wait_idle("t5_a");
    send_job(32'h00000009, 32'h0000000A, 4'h6, "t5_b");
    wait_out_rdy("t5");
    check("t5_head_before", bus.res_data, 32'hAAAA0001);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    check("t5_valid_after", bus.res_valid, 1);
    check("t5_head_after", bus.res_data, 32'hBBBB0002);
    wait_idle("t5_b");
    pop_check("t5_pop", 32'hBBBB0002, 1'b0);
    @(negedge clk);
    check("t5_empty", bus.res_valid, 0);

    // 6: reset during WAIT_RES with one entry already queued
    res_q.push_back(32'h0F0F0F0F);
    send_job(32'h0000000B, 32'h0000000C, 4'h8, "t6_x");
    wait_idle("t6_x");
    res_delay = 10;
    res_q.push_back(32'hF0F0F0F0);
    send_job(32'h0000000D, 32'h0000000E, 4'hA, "t6_y");
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!bus.fpu_input_rdy) break;
    end
    @(negedge clk);
    #1;
    check("t6_busy_before", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("t6_no_entry", bus.res_valid, 0);
    check("t6_idle", bus.busy, 0);
    res_delay = 5;
    res_q.push_back(32'h76543210);
    send_job(32'h0000000F, 32'h00000010, 4'hB, "t6_z");
    wait_idle("t6_z");
    pop_check("t6_z_pop", 32'h76543210, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
